ldm_stm_seq: RTL

Multi-cycle sequencer for ARM LDM/STM block transfers. On an issued block-transfer instruction it stalls the core and walks the 16-bit register list one register per cycle. Each cycle it drives the data-memory address and the register-file read or write port; at the end it optionally writes the updated base back through the register file's second write port. It sits beside the main decoder and owns the register-file write ports and the data-memory port while busy.

---
 rtl/ldm_stm_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list one register per cycle.
// Optional base writeback is enabled by defining LDMSTM_BASE_WB_EN.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        l,
  input  logic        p,
  input  logic        u,
  input  logic        w,
  input  logic [3:0]  rn,
  input  logic [31:0] rn_val,
  input  logic [15:0] reglist,
  output logic [3:0]  ra2,
  input  logic [31:0] rd2,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        we4,
  output logic [3:0]  wa4,
  output logic [31:0] wd4,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           l_q, l_d;
  logic           wb_q, wb_d;
  logic [RW-1:0]  rn_q, rn_d;
  logic [LW-1:0]  list_q, list_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wbv_q, wbv_d;

  logic [CW-1:0]  n_c;
  logic [DW-1:0]  four_n_c;
  logic [DW-1:0]  first_addr_c;
  logic [DW-1:0]  wb_val_c;
  logic           wb_cond_c;
  logic [RW-1:0]  idx_c;
  logic           last_c;

  function automatic logic [CW-1:0] popcount(input logic [LW-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < int'(LW); k++) c = c + CW'(v[k]);
    return c;
  endfunction

  function automatic logic [RW-1:0] lowest_set(input logic [LW-1:0] v);
    logic [RW-1:0] idx;
    idx = '0;
    for (int k = int'(LW) - 1; k >= 0; k--) begin
      if (v[k]) idx = RW'(k);
    end
    return idx;
  endfunction

  // Start-cycle address and writeback value computation
  always_comb begin
    n_c      = popcount(reglist);
    four_n_c = {25'd0, n_c, 2'b00};
    wb_val_c = u ? (rn_val + four_n_c) : (rn_val - four_n_c);
    unique case ({p, u})
      2'b01:   first_addr_c = rn_val;                               // IA
      2'b11:   first_addr_c = rn_val + 32'd4;                       // IB
      2'b00:   first_addr_c = rn_val - four_n_c + 32'd4;            // DA
      default: first_addr_c = rn_val - four_n_c;                    // DB
    endcase
  end

`ifdef LDMSTM_BASE_WB_EN
  // A load that includes the base keeps the loaded value instead of the writeback
  assign wb_cond_c = w & ~(l & reglist[rn]) & (reglist != '0);
`else
  assign wb_cond_c = 1'b0;
  logic unused_wb_ok;
  assign unused_wb_ok = w ^ (^rn_q) ^ (^wbv_q) ^ wb_q;
`endif

  assign idx_c  = lowest_set(list_q);
  assign last_c = ((list_q & (list_q - LW'(1))) == '0);

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    wb_d     = wb_q;
    rn_d     = rn_q;
    list_d   = list_q;
    addr_d   = addr_q;
    wbv_d    = wbv_q;
    busy     = 1'b0;
    done     = 1'b0;
    ra2      = '0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    we4      = 1'b0;
    wa4      = '0;
    wd4      = '0;
    pc_we    = 1'b0;
    pc_wd    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          l_d     = l;
          rn_d    = rn;
          list_d  = reglist;
          addr_d  = first_addr_c;
          wbv_d   = wb_val_c;
          wb_d    = wb_cond_c;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (list_q != '0) begin
          if (l_q) begin
            if (idx_c == RW'(15)) begin
              pc_we = 1'b1;
              pc_wd = mem_rd;
            end else begin
              we3 = 1'b1;
              wa3 = idx_c;
              wd3 = mem_rd;
            end
          end else begin
            ra2    = idx_c;
            mem_we = 1'b1;
            mem_wd = rd2;
          end
        end
        list_d = list_q & ~(LW'(1) << idx_c);
        addr_d = addr_q + 32'd4;
        if (last_c) begin
          if (wb_q) begin
            state_d = S_WB;
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WB: begin
        busy = 1'b1;
        done = 1'b1;
`ifdef LDMSTM_BASE_WB_EN
        we4  = 1'b1;
        wa4  = rn_q;
        wd4  = wbv_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle never commits a write, even if the state is still active
    if (reset) begin
      mem_we = 1'b0;
      we3    = 1'b0;
      we4    = 1'b0;
      pc_we  = 1'b0;
      done   = 1'b0;
    end
  end

  assign stall = (start & (state_q == S_IDLE)) | busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      l_q     <= 1'b0;
      wb_q    <= 1'b0;
      rn_q    <= '0;
      list_q  <= '0;
      addr_q  <= '0;
      wbv_q   <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      wb_q    <= wb_d;
      rn_q    <= rn_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wbv_q   <= wbv_d;
    end
  end

endmodule
